// File: rtl/led_pattern_gen_if.sv
// led_pattern_gen_if: control inputs and LED/step outputs of the LED pattern sequencer
interface led_pattern_gen_if #(parameter int NUM_LEDS = 8);
  logic [1:0] mode;
  logic [1:0] speed;
  logic pause;
  logic [NUM_LEDS-1:0] LEDR;
  logic step;
  modport master(output mode, speed, pause, input LEDR, step);
  modport slave(input mode, speed, pause, output LEDR, step);
endinterface

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: LED animation sequencer with rotate, bounce and blink modes
module led_pattern_gen #(
  parameter int NUM_LEDS = 8,
  parameter int CLK_HZ = 50_000_000,
  parameter int STEP_HZ = 2
) (
  input logic CLOCK_50,
  input logic RESET,
  led_pattern_gen_if.slave bus
);
  localparam int DIV = CLK_HZ / STEP_HZ;
  localparam int CW = $clog2(DIV);
  logic [CW-1:0] cnt, p_m1;
  logic [NUM_LEDS-1:0] leds, nxt, sh, seed;
  logic [1:0] mode_q;
  logic dir, ndir, stp, tick;
  always_comb begin
    p_m1 = CW'((DIV >> bus.speed) - 1);
    tick = cnt >= p_m1;
    sh = dir ? leds >> 1 : leds << 1;
    seed = bus.mode == 2'd3 ? '1 : NUM_LEDS'(1);
    nxt = bus.mode == 2'd0 ? {leds[NUM_LEDS-2:0], leds[NUM_LEDS-1]} :
          bus.mode == 2'd1 ? {leds[0], leds[NUM_LEDS-1:1]} :
          bus.mode == 2'd2 ? sh : ~leds;
    // dir: 0 sweeps toward the MSB, 1 toward the LSB; flips when an end LED is reached
    ndir = bus.mode == 2'd2 ? (dir ? !sh[0] : sh[NUM_LEDS-1]) : dir;
  end
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      leds <= NUM_LEDS'(1);
      stp <= 1'b0;
      cnt <= '0;
      dir <= 1'b0;
      mode_q <= 2'd0;
    end else begin
      mode_q <= bus.mode;
      stp <= 1'b0;
      if (bus.mode != mode_q) begin
        leds <= seed;
        cnt <= '0;
        dir <= 1'b0;
      end else if (!bus.pause) begin
        if (tick) begin
          cnt <= '0;
          stp <= 1'b1;
          leds <= nxt;
          dir <= ndir;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
  assign bus.LEDR = leds;
  assign bus.step = stp;
endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: random stimulus, index-based reference model, queued event scoreboard
module tb_led_pattern_gen;
  localparam int N = 4;
  localparam int DIV = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  led_pattern_gen_if #(.NUM_LEDS(N)) bus();
  led_pattern_gen #(.NUM_LEDS(N), .CLK_HZ(16), .STEP_HZ(2)) dut (
    .CLOCK_50(clk),
    .RESET(rst),
    .bus(bus)
  );
  typedef struct {int cyc; logic [N-1:0] leds; logic stp;} ev_t;
  ev_t q[$];
  ev_t e;
  int cyc = 0;
  int checks = 0;
  int passed = 0;
  bit mon_en = 0;
  bit fin = 0;
  logic [N-1:0] prev = N'(1);
  int m_mode = 0, cnt = 0, pos = 0, ph = 0;
  bit on = 0;
  logic [N-1:0] m_leds = N'(1);

  // Pattern expressed as a lit-LED index (rotate/bounce) or an on/off phase (blink)
  function automatic logic [N-1:0] leds_of();
    logic [N-1:0] one = N'(1);
    if (m_mode <= 1) return one << pos;
    if (m_mode == 2) return one << (ph < N ? ph : 2 * N - 2 - ph);
    return on ? '1 : '0;
  endfunction

  task automatic model_edge();
    logic [N-1:0] old = m_leds;
    bit stp = 0;
    if (rst) begin
      m_mode = 0; cnt = 0; pos = 0; ph = 0; on = 0;
    end else if (int'(bus.mode) != m_mode) begin
      m_mode = int'(bus.mode); cnt = 0; pos = 0; ph = 0; on = 1;
    end else if (!bus.pause) begin
      if (cnt >= (DIV >> bus.speed) - 1) begin
        cnt = 0;
        stp = 1;
        if (m_mode == 0) pos = (pos + 1) % N;
        else if (m_mode == 1) pos = (pos + N - 1) % N;
        else if (m_mode == 2) ph = (ph + 1) % (2 * N - 2);
        else on = !on;
      end else cnt++;
    end
    m_leds = leds_of();
    if (stp || m_leds != old) q.push_back('{cyc, m_leds, stp});
  endtask

  task automatic tick_edge();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
  endtask

  task automatic run(input int md, input int spd, input bit pz, input int n);
    bus.mode = 2'(md);
    bus.speed = 2'(spd);
    bus.pause = pz;
    repeat (n) tick_edge();
  endtask

  always @(negedge clk) begin
    if (fin) begin
      checks++;
      if (q.size() == 0) passed++;
      else $display("FAIL missing_events: %0d expected events never seen, first at cyc %0d", q.size(), q[0].cyc);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
    end else if (mon_en && (bus.step || bus.LEDR != prev)) begin
      checks++;
      if (q.size() == 0) begin
        $display("FAIL unexpected_event: cyc %0d LEDR=%b step=%b, expected no event", cyc, bus.LEDR, bus.step);
      end else begin
        e = q.pop_front();
        if (e.cyc == cyc && e.leds == bus.LEDR && e.stp == bus.step) passed++;
        else $display("FAIL event: got cyc %0d LEDR=%b step=%b, expected cyc %0d LEDR=%b step=%b",
                      cyc, bus.LEDR, bus.step, e.cyc, e.leds, e.stp);
      end
      prev = bus.LEDR;
    end
  end

  initial begin
    bus.mode = 2'd0;
    bus.speed = 2'd0;
    bus.pause = 1'b0;
    rst = 1'b1;
    repeat (2) tick_edge();
    mon_en = 1;
    rst = 1'b0;
    run(0, 0, 0, 40);
    run(0, 0, 0, 6);
    run(0, 2, 0, 12);
    run(2, 0, 0, 60);
    run(3, 0, 0, 30);
    run(3, 0, 0, 3);
    run(1, 0, 0, 20);
    run(1, 0, 0, 5);
    run(1, 0, 1, 20);
    run(1, 0, 0, 10);
    run(2, 0, 1, 4);
    run(2, 0, 0, 40);
    rst = 1'b1;
    tick_edge();
    rst = 1'b0;
    run(2, 0, 0, 20);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 149) == 0) bus.mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) bus.speed = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 59) == 0) bus.pause = !bus.pause;
      rst = $urandom_range(0, 499) == 0;
      tick_edge();
    end
    rst = 1'b0;
    bus.pause = 1'b0;
    repeat (3) tick_edge();
    @(negedge clk);
    #1 fin = 1;
  end
endmodule
